// File: rtl/aes_round_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | aes_round_ctrl: iterative AES-128 round sequencer (state reg, AddRoundKey).  |
// | Optional AES_DEC_EN adds dec/dp_inv for decryption. Revision: 1.0           |
// +-----------------------------------------------------------------------------+
module aes_round_ctrl (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_DEC_EN
  input  logic         dec,
  output logic         dp_inv,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  output logic [3:0]   rk_idx,
  input  logic [0:127] rk,
  output logic [0:127] dp_state,
  output logic         dp_last,
  input  logic [0:127] dp_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy
);

  localparam logic [3:0] NR      = 4'd10;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]   fsm_q,   fsm_d;
  logic [0:127] state_q, state_d;
  logic [3:0]   round_q, round_d;

`ifdef AES_DEC_EN
  logic dec_q, dec_d;
`endif

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
`ifdef AES_DEC_EN
    dec_d   = dec_q;
`endif
    case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = in_data ^ rk;
          round_d = 4'd1;
          fsm_d   = S_ROUND;
`ifdef AES_DEC_EN
          dec_d   = dec;
`endif
        end
      end
      S_ROUND: begin
        state_d = dp_result ^ rk;
        if (round_q == NR) begin
          fsm_d = S_HOLD;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          fsm_d   = S_IDLE;
          round_d = 4'd0;
        end
      end
      default: begin
        fsm_d   = S_IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      round_q <= 4'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

`ifdef AES_DEC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q <= 1'b0;
    end else begin
      dec_q <= dec_d;
    end
  end

  assign dp_inv = dec_q;

  // Decryption walks the key schedule backwards; IDLE uses the live dec input
  // because the initial AddRoundKey happens on the accepting edge.
  always_comb begin
    rk_idx = 4'd0;
    if (fsm_q == S_IDLE) begin
      rk_idx = dec ? NR : 4'd0;
    end else if (fsm_q == S_ROUND) begin
      rk_idx = dec_q ? (NR - round_q) : round_q;
    end
  end
`else
  always_comb begin
    rk_idx = 4'd0;
    if (fsm_q == S_ROUND) begin
      rk_idx = round_q;
    end
  end
`endif

  assign in_ready  = (fsm_q == S_IDLE);
  assign busy      = (fsm_q != S_IDLE);
  assign out_valid = (fsm_q == S_HOLD);
  assign out_data  = state_q;
  assign dp_state  = state_q;
  assign dp_last   = (fsm_q == S_ROUND) && (round_q == NR);

endmodule
`default_nettype wire
